// File: rtl/bnw_game_pkg.sv
// Shared constants and helpers for the black-and-white piano game.
// Holds the screen geometry defaults for falling blocks, the beat counter
// width, and the schedule matcher used by every note lane.
package bnw_game_pkg;

  localparam int H_W_DEF     = 10;
  localparam int BEAT_W_DEF  = 7;
  localparam int SPAWN_H_DEF = 120;
  localparam int OFF_H_DEF   = 720;

  // Upper bounds of the schedule matcher: at most SCHED_MAX_ENT entries of
  // at most BEAT_W_MAX bits each, packed into SCHED_MAX_BITS.
  localparam int BEAT_W_MAX     = 16;
  localparam int SCHED_MAX_ENT  = 32;
  localparam int SCHED_MAX_BITS = 512;

  // True when beat equals any of the first sched_len entries of sched.
  // Entry i lives at bits [i*beat_w +: beat_w]; entry 0 in the LSBs.
  // Duplicate entries simply match more than once, which is harmless.
  function automatic logic sched_match(
    input logic [BEAT_W_MAX-1:0]     beat,
    input logic [SCHED_MAX_BITS-1:0] sched,
    input int                        sched_len,
    input int                        beat_w
  );
    logic                  found;
    logic [BEAT_W_MAX-1:0] entry;
    found = 1'b0;
    for (int i = 0; i < SCHED_MAX_ENT; i++) begin
      entry = '0;
      if (i < sched_len) begin
        for (int b = 0; b < BEAT_W_MAX; b++) begin
          if (b < beat_w) entry[b] = sched[i*beat_w + b];
        end
        if (entry == beat) found = 1'b1;
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/note_slot.sv
// One falling-block height register.
// clear (or reset) parks the slot at OFF_H, load places a new block at
// SPAWN_H, advance moves an active block down by STEP and saturates at
// OFF_H, which frees the slot. expired flags the edge on which motion
// alone frees the slot.
module note_slot #(
  parameter int H_W     = 10,
  parameter int SPAWN_H = 120,
  parameter int OFF_H   = 720,
  parameter int STEP    = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           clear,
  input  logic           advance,
  output logic [H_W-1:0] h,
  output logic           active,
  output logic           expired
);

  localparam logic [H_W-1:0] SPAWN_V = H_W'(SPAWN_H);
  localparam logic [H_W-1:0] OFF_V   = H_W'(OFF_H);
  localparam logic [H_W:0]   OFF_X   = (H_W+1)'(OFF_H);
  localparam logic [H_W:0]   STEP_X  = (H_W+1)'(STEP);

  logic [H_W:0]   sum;
  logic           sat;
  logic [H_W-1:0] next_h;

  // One extra bit on the sum so a large STEP can never wrap to a low height.
  always_comb begin
    sum     = {1'b0, h} + STEP_X;
    sat     = (sum >= OFF_X);
    next_h  = sat ? OFF_V : sum[H_W-1:0];
    active  = (h != OFF_V);
    expired = active && advance && !clear && sat;
  end

  // Height register: clear beats load beats motion; free slots stay parked.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      h <= OFF_V;
    end else if (load) begin
      h <= SPAWN_V;
    end else if (advance && active) begin
      h <= next_h;
    end
  end

endmodule

// File: rtl/note_lane_gen.sv
// Falling-note lane: NUM_SLOTS concurrent blocks, spawned on beat-count
// edges that appear in SCHED and moved down by STEP per tick.
// Build option NOTE_LANE_HIT_JUDGE_EN enables key-press judging (hit/miss);
// without it hit and miss are held at 0 and key_press is ignored.
// Handshake note: there is no valid/ready traffic here; every pulse output
// (spawn_ovf, hit, miss) is a registered single-cycle strobe, high for
// exactly the one cycle following the edge that sampled its cause.
module note_lane_gen
  import bnw_game_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int H_W       = H_W_DEF,
  parameter int BEAT_W    = BEAT_W_DEF,
  parameter int SPAWN_H   = SPAWN_H_DEF,
  parameter int OFF_H     = OFF_H_DEF,
  parameter int STEP      = 1,
  parameter int SCHED_LEN = 5,
  parameter logic [SCHED_LEN*BEAT_W-1:0] SCHED = {7'd92, 7'd56, 7'd32, 7'd20, 7'd2},
  parameter int HIT_LO    = 600,
  parameter int HIT_HI    = 680
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     restart,
  input  logic                     stop_or_endgame,
  input  logic [BEAT_W-1:0]        beat_cnt,
  input  logic                     key_press,
  output logic [NUM_SLOTS*H_W-1:0] block_h,
  output logic [NUM_SLOTS-1:0]     slot_active,
  output logic                     spawn_ovf,
  output logic                     hit,
  output logic                     miss
);

  localparam logic [SCHED_MAX_BITS-1:0] SCHED_PAD = SCHED_MAX_BITS'(SCHED);

  logic                 lane_rst;
  logic [BEAT_W-1:0]    pre_beat;
  logic                 beat_add;
  logic                 spawn_req;
  logic                 any_free;
  logic [NUM_SLOTS-1:0] load_vec;
  logic [NUM_SLOTS-1:0] clear_vec;
  logic [NUM_SLOTS-1:0] expired_vec;
  logic [H_W-1:0]       h_arr [NUM_SLOTS];

  assign lane_rst = rst || restart;

  // Spawn request: rising beat count that lands on a scheduled beat.
  always_comb begin
    beat_add  = (beat_cnt > pre_beat);
    spawn_req = beat_add &&
                sched_match(BEAT_W_MAX'(beat_cnt), SCHED_PAD, SCHED_LEN, BEAT_W);
  end

  // Priority allocator: lowest-index slot that is free before this edge.
  // A slot freed on this edge (motion or hit) still reads active here, so
  // it only becomes allocatable from the next edge.
  always_comb begin
    load_vec = '0;
    any_free = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!slot_active[i] && !any_free) begin
        load_vec[i] = spawn_req;
        any_free    = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    note_slot #(
      .H_W     (H_W),
      .SPAWN_H (SPAWN_H),
      .OFF_H   (OFF_H),
      .STEP    (STEP)
    ) u_slot (
      .clk     (clk),
      .rst     (lane_rst),
      .load    (load_vec[g]),
      .clear   (clear_vec[g]),
      .advance (!stop_or_endgame),
      .h       (h_arr[g]),
      .active  (slot_active[g]),
      .expired (expired_vec[g])
    );
    assign block_h[g*H_W +: H_W] = h_arr[g];
  end

  // Beat history and spawn overflow strobe.
  always_ff @(posedge clk) begin
    if (lane_rst) begin
      pre_beat  <= '0;
      spawn_ovf <= 1'b0;
    end else begin
      pre_beat  <= beat_cnt;
      spawn_ovf <= spawn_req && !any_free;
    end
  end

`ifdef NOTE_LANE_HIT_JUDGE_EN

  localparam logic [H_W-1:0] HIT_LO_V = H_W'(HIT_LO);
  localparam logic [H_W-1:0] HIT_HI_V = H_W'(HIT_HI);

  logic                 tgt_found;
  logic [H_W-1:0]       best_h;
  logic [NUM_SLOTS-1:0] tgt_sel;

  // Hit target: in-window active slot with the largest pre-edge height;
  // strict compare keeps the lowest index on ties.
  always_comb begin
    tgt_found = 1'b0;
    best_h    = '0;
    tgt_sel   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_active[i] && (h_arr[i] >= HIT_LO_V) && (h_arr[i] <= HIT_HI_V) &&
          (!tgt_found || (h_arr[i] > best_h))) begin
        tgt_found  = 1'b1;
        best_h     = h_arr[i];
        tgt_sel    = '0;
        tgt_sel[i] = 1'b1;
      end
    end
    clear_vec = (key_press && tgt_found) ? tgt_sel : '0;
  end

  // Judge strobes: a press miss and an expiry on the same edge merge.
  always_ff @(posedge clk) begin
    if (lane_rst) begin
      hit  <= 1'b0;
      miss <= 1'b0;
    end else begin
      hit  <= key_press && tgt_found;
      miss <= (key_press && !tgt_found) || (|expired_vec);
    end
  end

`else

  logic unused_judge;

  // Judging disabled: expiry frees slots silently and presses are ignored.
  always_comb begin
    clear_vec    = '0;
    unused_judge = key_press ^ (|expired_vec);
  end

  assign hit  = 1'b0;
  assign miss = 1'b0;

`endif

endmodule

// File: tb/tb_note_lane_gen.sv
// Directed bench for note_lane_gen. Instance a uses the default lane;
// instance b is a two-slot lane with STEP 7, SPAWN_H 119 and a duplicated
// schedule entry, to reach overflow and saturation quickly.
// Expectations for hit/miss follow NOTE_LANE_HIT_JUDGE_EN.
module tb_note_lane_gen;

`ifdef NOTE_LANE_HIT_JUDGE_EN
  localparam logic JUDGE = 1'b1;
`else
  localparam logic JUDGE = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_restart = 1'b0, a_stop = 1'b0, a_key = 1'b0;
  logic [6:0]  a_beat = '0;
  logic [39:0] a_h;
  logic [3:0]  a_act;
  logic        a_ovf, a_hit, a_miss;

  logic        b_restart = 1'b0, b_stop = 1'b0, b_key = 1'b0;
  logic [6:0]  b_beat = '0;
  logic [19:0] b_h;
  logic [1:0]  b_act;
  logic        b_ovf, b_hit, b_miss;

  int checks   = 0;
  int failures = 0;

  note_lane_gen u_a (
    .clk(clk), .rst(rst), .restart(a_restart), .stop_or_endgame(a_stop),
    .beat_cnt(a_beat), .key_press(a_key), .block_h(a_h), .slot_active(a_act),
    .spawn_ovf(a_ovf), .hit(a_hit), .miss(a_miss)
  );

  note_lane_gen #(
    .NUM_SLOTS(2), .STEP(7), .SPAWN_H(119), .SCHED_LEN(4),
    .SCHED({7'd5, 7'd4, 7'd3, 7'd3})
  ) u_b (
    .clk(clk), .rst(rst), .restart(b_restart), .stop_or_endgame(b_stop),
    .beat_cnt(b_beat), .key_press(b_key), .block_h(b_h), .slot_active(b_act),
    .spawn_ovf(b_ovf), .hit(b_hit), .miss(b_miss)
  );

  // driver: advance n edges, settle 1 time unit past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // scoreboard check
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // reset
    tick(2);
    rst = 1'b0;
    chk("rst_a_h",   a_h,   {4{10'd720}});
    chk("rst_a_act", a_act, 4'b0000);
    chk("rst_a_ovf", a_ovf, 1'b0);
    chk("rst_a_hit", a_hit, 1'b0);
    chk("rst_a_miss", a_miss, 1'b0);
    chk("rst_b_h",   b_h,   {2{10'd720}});

    // single block spawns at beat 2 and falls to expiry
    a_beat = 7'd2;
    tick(1);
    chk("t1_spawn_h",   a_h,   {10'd720, 10'd720, 10'd720, 10'd120});
    chk("t1_spawn_act", a_act, 4'b0001);
    tick(599);
    chk("t1_719_h",    a_h,    {10'd720, 10'd720, 10'd720, 10'd719});
    chk("t1_719_miss", a_miss, 1'b0);
    tick(1);
    chk("t1_exp_h",    a_h,    {4{10'd720}});
    chk("t1_exp_act",  a_act,  4'b0000);
    chk("t1_exp_miss", a_miss, JUDGE);
    tick(1);
    chk("t1_miss_drop", a_miss, 1'b0);

    // restart, then two overlapping blocks (beats 2 and 20)
    a_restart = 1'b1;
    tick(1);
    a_restart = 1'b0;
    chk("t2_restart_h", a_h, {4{10'd720}});
    tick(1);
    chk("t2_spawn0", a_h, {10'd720, 10'd720, 10'd720, 10'd120});
    tick(17);
    a_beat = 7'd20;
    tick(1);
    chk("t2_two_h",   a_h,   {10'd720, 10'd720, 10'd120, 10'd138});
    chk("t2_two_act", a_act, 4'b0011);

    // freeze with a block at 300, spawn still accepted at beat 32
    tick(162);
    chk("t6_pre_h", a_h, {10'd720, 10'd720, 10'd282, 10'd300});
    a_stop = 1'b1;
    a_beat = 7'd32;
    tick(1);
    chk("t6_stop_spawn_h", a_h,   {10'd720, 10'd120, 10'd282, 10'd300});
    chk("t6_stop_act",     a_act, 4'b0111);
    tick(5);
    chk("t6_stop_hold_h", a_h, {10'd720, 10'd120, 10'd282, 10'd300});

    // press with blocks at 650 and 632 in the window
    a_stop = 1'b0;
    tick(350);
    chk("t5_pre_h", a_h, {10'd720, 10'd470, 10'd632, 10'd650});
    a_key = 1'b1;
    tick(1);
    a_key = 1'b0;
    chk("t5_hit_h",    a_h,    JUDGE ? {10'd720, 10'd471, 10'd633, 10'd720}
                                     : {10'd720, 10'd471, 10'd633, 10'd651});
    chk("t5_hit_act",  a_act,  JUDGE ? 4'b0110 : 4'b0111);
    chk("t5_hit",      a_hit,  JUDGE);
    chk("t5_hit_miss", a_miss, 1'b0);
    tick(1);
    chk("t5_hit_drop", a_hit, 1'b0);

    // restart mid-flight, then press with nothing on screen
    a_restart = 1'b1;
    a_beat    = 7'd0;
    tick(1);
    a_restart = 1'b0;
    chk("t6_restart_h",   a_h,   {4{10'd720}});
    chk("t6_restart_act", a_act, 4'b0000);
    a_key = 1'b1;
    tick(1);
    a_key = 1'b0;
    chk("t5_empty_miss", a_miss, JUDGE);
    chk("t5_empty_hit",  a_hit,  1'b0);
    tick(1);
    chk("t5_miss_drop", a_miss, 1'b0);

    // falling beat count does not spawn
    a_beat = 7'd56;
    tick(1);
    a_beat = 7'd20;
    tick(1);
    chk("beat_down_h",   a_h,   {10'd720, 10'd720, 10'd720, 10'd121});
    chk("beat_down_act", a_act, 4'b0001);

    // two-slot lane: duplicate entry spawns once, third spawn overflows
    b_beat = 7'd3;
    tick(1);
    chk("b_dup_h",   b_h,   {10'd720, 10'd119});
    chk("b_dup_act", b_act, 2'b01);
    b_beat = 7'd4;
    tick(1);
    chk("b_two_h", b_h, {10'd119, 10'd126});
    chk("b_two_ovf", b_ovf, 1'b0);
    b_beat = 7'd5;
    tick(1);
    chk("b_ovf",     b_ovf, 1'b1);
    chk("b_ovf_h",   b_h,   {10'd126, 10'd133});
    chk("b_ovf_act", b_act, 2'b11);
    tick(1);
    chk("b_ovf_drop", b_ovf, 1'b0);
    chk("b_t3_h",     b_h,   {10'd133, 10'd140});

    // STEP 7 saturation: 714 -> 720, no wrap
    tick(82);
    chk("b_714_h", b_h, {10'd707, 10'd714});
    tick(1);
    chk("b_sat_h",   b_h,   {10'd714, 10'd720});
    chk("b_sat_act", b_act, 2'b10);
    tick(1);
    chk("b_sat2_h",   b_h,   {2{10'd720}});
    chk("b_sat2_act", b_act, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
